// File: rtl/lorenz_pkg.sv
// Shared fixed-point definitions for the Lorenz Euler integrator (7.20 signed format).
package lorenz_pkg;

    localparam int W    = 27;
    localparam int FRAC = 20;

    typedef logic signed [W-1:0] fx_t;

    localparam fx_t FX_ONE = fx_t'(1 << FRAC);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_STEP = 1'b1
    } state_e;

    // Full-precision product, arithmetic shift, keep low W bits (rounds toward -inf).
    function automatic fx_t fmul(input fx_t a, input fx_t b);
        logic signed [2*W-1:0] prod;
        prod = a * b;
        return fx_t'(prod >>> FRAC);
    endfunction

endpackage

// File: rtl/lorenz_euler_integrator_fx_mul.sv
// Signed fixed-point multiplier: W x W product, shifted right by FRAC, truncated to W bits.
module fx_mul #(
    parameter int W    = 27,
    parameter int FRAC = 20
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p
);

    logic signed [2*W-1:0] prod;

    assign prod = $signed(a) * $signed(b);
    assign p    = W'(prod >>> FRAC);

endmodule

// File: rtl/lorenz_euler_integrator.sv
// Forward-Euler Lorenz attractor solver stepping x/y/z at a programmable rate.
module lorenz_euler_integrator #(
    parameter int W     = lorenz_pkg::W,
    parameter int FRAC  = lorenz_pkg::FRAC,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             init_load,
    input  logic             run,
    input  logic [31:0]      step_div,
    input  logic [W-1:0]     x0,
    input  logic [W-1:0]     y0,
    input  logic [W-1:0]     z0,
    input  logic [W-1:0]     sigma,
    input  logic [W-1:0]     beta,
    input  logic [W-1:0]     rho,
    input  logic [W-1:0]     dt,
    output logic [OUT_W-1:0] x_out,
    output logic [OUT_W-1:0] y_out,
    output logic [OUT_W-1:0] z_out,
    output logic [31:0]      step_count,
    output logic             step_valid
);

    import lorenz_pkg::*;

    logic [W-1:0] x_q, y_q, z_q, x_d, y_d, z_d;
    logic [31:0]  div_cnt_q, div_cnt_d;
    logic [31:0]  step_count_q, step_count_d;
    logic         step_valid_q, step_valid_d;
    state_e       state_q, state_d;

    logic [W-1:0] y_m_x, rho_m_z;
    logic [W-1:0] dx, x_rz, xy, bz, dy, dz;
    logic [W-1:0] dt_dx, dt_dy, dt_dz;
    logic [W-1:0] x_n, y_n, z_n;

    // Derivatives; all adds/subtracts wrap at W bits.
    assign y_m_x   = y_q - x_q;
    assign rho_m_z = rho - z_q;

    fx_mul #(.W(W), .FRAC(FRAC)) u_mul_sigma (.a(sigma), .b(y_m_x),   .p(dx));
    fx_mul #(.W(W), .FRAC(FRAC)) u_mul_xrz   (.a(x_q),   .b(rho_m_z), .p(x_rz));
    fx_mul #(.W(W), .FRAC(FRAC)) u_mul_xy    (.a(x_q),   .b(y_q),     .p(xy));
    fx_mul #(.W(W), .FRAC(FRAC)) u_mul_bz    (.a(beta),  .b(z_q),     .p(bz));

    assign dy = x_rz - y_q;
    assign dz = xy - bz;

    fx_mul #(.W(W), .FRAC(FRAC)) u_mul_dtx (.a(dt), .b(dx), .p(dt_dx));
    fx_mul #(.W(W), .FRAC(FRAC)) u_mul_dty (.a(dt), .b(dy), .p(dt_dy));
    fx_mul #(.W(W), .FRAC(FRAC)) u_mul_dtz (.a(dt), .b(dz), .p(dt_dz));

    assign x_n = x_q + dt_dx;
    assign y_n = y_q + dt_dy;
    assign z_n = z_q + dt_dz;

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        div_cnt_d    = div_cnt_q;
        step_count_d = step_count_q;
        step_valid_d = 1'b0;
        state_d      = state_q;

        case (state_q)
            ST_IDLE: if (run && !init_load) state_d = ST_STEP;
            ST_STEP: if (!run || init_load) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (init_load) begin
            x_d          = x0;
            y_d          = y0;
            z_d          = z0;
            div_cnt_d    = '0;
            step_count_d = '0;
        end else if (run) begin
            if (div_cnt_q == step_div) begin
                x_d          = x_n;
                y_d          = y_n;
                z_d          = z_n;
                div_cnt_d    = '0;
                step_count_d = step_count_q + 32'd1;
                step_valid_d = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 32'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the async reset clears every flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            div_cnt_q    <= '0;
            step_count_q <= '0;
            step_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            z_q          <= z_d;
            div_cnt_q    <= div_cnt_d;
            step_count_q <= step_count_d;
            step_valid_q <= step_valid_d;
            state_q      <= state_d;
        end
    end

    assign x_out      = {{(OUT_W-W){x_q[W-1]}}, x_q};
    assign y_out      = {{(OUT_W-W){y_q[W-1]}}, y_q};
    assign z_out      = {{(OUT_W-W){z_q[W-1]}}, z_q};
    assign step_count = step_count_q;
    assign step_valid = step_valid_q;

endmodule

// File: tb/tb_lorenz_euler_integrator.sv
// Self-checking bench: plain-arithmetic Lorenz model compared every cycle, plus directed literals.
module tb_lorenz_euler_integrator;

    localparam int W = 27;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          init_load = 1'b0;
    logic          run = 1'b0;
    logic [31:0]   step_div = '0;
    logic [W-1:0]  x0 = '0, y0 = '0, z0 = '0;
    logic [W-1:0]  sigma = '0, beta = '0, rho = '0, dt = '0;
    logic [31:0]   x_out, y_out, z_out, step_count;
    logic          step_valid;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    bit force_cnt = 1'b0;

    lorenz_euler_integrator dut (
        .clk(clk), .reset_n(reset_n), .init_load(init_load), .run(run),
        .step_div(step_div), .x0(x0), .y0(y0), .z0(z0),
        .sigma(sigma), .beta(beta), .rho(rho), .dt(dt),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .step_count(step_count), .step_valid(step_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integers, wrapped back to the 27-bit signed range.
    function automatic longint wrap(input longint v);
        logic [W-1:0] t;
        t = v[W-1:0];
        return longint'($signed(t));
    endfunction

    function automatic longint sv(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint fm(input longint a, input longint b);
        longint p;
        p = a * b;
        p = p >>> 20;
        return wrap(p);
    endfunction

    longint      mx = 0, my = 0, mz = 0;
    logic [31:0] mdiv = '0, mcnt = '0;
    logic        mvalid = 1'b0;

    always @(posedge clk or negedge reset_n) begin : model
        longint ddx, ddy, ddz;
        if (!reset_n) begin
            mx = 0; my = 0; mz = 0; mdiv = '0; mcnt = '0; mvalid = 1'b0;
        end else begin
            if (force_cnt) mcnt = 32'hFFFF_FFFE;
            if (init_load) begin
                mx = sv(x0); my = sv(y0); mz = sv(z0);
                mdiv = '0; mcnt = '0; mvalid = 1'b0;
            end else if (run) begin
                if (mdiv == step_div) begin
                    ddx = fm(sv(sigma), wrap(my - mx));
                    ddy = wrap(fm(mx, wrap(sv(rho) - mz)) - my);
                    ddz = wrap(fm(mx, my) - fm(sv(beta), mz));
                    mx = wrap(mx + fm(sv(dt), ddx));
                    my = wrap(my + fm(sv(dt), ddy));
                    mz = wrap(mz + fm(sv(dt), ddz));
                    mdiv = '0;
                    mcnt = mcnt + 32'd1;
                    mvalid = 1'b1;
                end else begin
                    mdiv = mdiv + 32'd1;
                    mvalid = 1'b0;
                end
            end else begin
                mvalid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && reset_n) begin
            check("model_x", x_out, 32'(mx));
            check("model_y", y_out, 32'(my));
            check("model_z", z_out, 32'(mz));
            check("model_count", step_count, mcnt);
            check("model_valid", {31'd0, step_valid}, {31'd0, mvalid});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input longint lx, input longint ly, input longint lz,
                        input longint ls, input longint lr, input longint lb, input longint ld);
        x0 = W'(lx); y0 = W'(ly); z0 = W'(lz);
        sigma = W'(ls); rho = W'(lr); beta = W'(lb); dt = W'(ld);
        run = 1'b0;
        init_load = 1'b1;
        cyc(1);
        init_load = 1'b0;
    endtask

    task automatic load_classic();
        load(-1048576, 1048576, 26214400, 10485760, 29360128, 2097152, 4096);
    endtask

    initial begin : stim
        int k, last, pulses;
        logic [31:0] sc, xs;
        bit seen;

        cyc(2);
        reset_n = 1'b1;
        cmp_en = 1'b1;
        cyc(1);
        check("reset_x", x_out, 32'd0);
        check("reset_count", step_count, 32'd0);
        check("reset_valid", {31'd0, step_valid}, 32'd0);

        // Asynchronous reset in the middle of a run.
        load_classic();
        step_div = 32'd1;
        run = 1'b1;
        cyc(5);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_x", x_out, 32'd0);
        check("async_rst_y", y_out, 32'd0);
        check("async_rst_z", z_out, 32'd0);
        check("async_rst_count", step_count, 32'd0);
        check("async_rst_valid", {31'd0, step_valid}, 32'd0);
        run = 1'b0;
        cyc(1);
        reset_n = 1'b1;

        // Origin is a fixed point: state stays zero, count advances.
        step_div = 32'd0;
        run = 1'b1;
        cyc(5);
        check("fixed_point_count", step_count, 32'd5);
        check("fixed_point_x", x_out, 32'd0);
        check("fixed_point_z", z_out, 32'd0);
        run = 1'b0;

        // Single Euler step from (-1, 1, 25).
        load_classic();
        step_div = 32'd0;
        run = 1'b1;
        cyc(1);
        run = 1'b0;
        check("single_x", x_out, 32'(-966656));
        check("single_y", y_out, 32'd1032192);
        check("single_z", z_out, 32'd26005504);
        check("single_count", step_count, 32'd1);
        check("single_valid", {31'd0, step_valid}, 32'd1);
        cyc(1);
        check("single_pulse_end", {31'd0, step_valid}, 32'd0);

        // Rate: step_div=3 gives a pulse every 4 cycles, first one 4 cycles after run.
        load_classic();
        step_div = 32'd3;
        run = 1'b1;
        last = 0;
        pulses = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (step_valid) begin
                pulses++;
                check("rate_interval", 32'(i - last), 32'd4);
                last = i;
                if (pulses == 10) break;
            end
        end
        check("rate_pulses", 32'(pulses), 32'd10);
        check("rate_count", step_count, 32'd10);

        // Pause two cycles into a count; resume must finish the remaining count.
        cyc(2);
        sc = step_count;
        xs = x_out;
        run = 1'b0;
        cyc(7);
        check("pause_count", step_count, sc);
        check("pause_x", x_out, xs);
        run = 1'b1;
        k = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (step_valid) begin
                k = i;
                seen = 1'b1;
                break;
            end
        end
        check("resume_seen", {31'd0, seen}, 32'd1);
        check("resume_latency", 32'(k), 32'd2);

        // init_load wins over an update edge.
        step_div = 32'd0;
        cyc(2);
        init_load = 1'b1;
        cyc(1);
        init_load = 1'b0;
        run = 1'b0;
        check("prio_x", x_out, 32'hFFF0_0000);
        check("prio_y", y_out, 32'h0010_0000);
        check("prio_z", z_out, 32'd26214400);
        check("prio_count", step_count, 32'd0);
        check("prio_valid", {31'd0, step_valid}, 32'd0);

        // step_count wraps from 0xFFFFFFFF to 0.
        #2 force dut.step_count_q = 32'hFFFF_FFFE;
        force_cnt = 1'b1;
        #1 release dut.step_count_q;
        @(negedge clk);
        force_cnt = 1'b0;
        check("preload_count", step_count, 32'hFFFF_FFFE);
        run = 1'b1;
        cyc(1);
        check("wrap_count_max", step_count, 32'hFFFF_FFFF);
        cyc(1);
        run = 1'b0;
        check("wrap_count_zero", step_count, 32'd0);
        check("wrap_count_valid", {31'd0, step_valid}, 32'd1);

        // State arithmetic wraps outside the 7.20 range.
        load(-33554432, 33554432, 0, 1048576, 0, 0, 1048576);
        run = 1'b1;
        cyc(1);
        run = 1'b0;
        check("state_wrap_x", x_out, 32'h0200_0000);
        check("state_wrap_y", y_out, 32'd0);
        check("state_wrap_z", z_out, 32'd0);

        // Coefficient changes between steps take effect at the next update.
        load_classic();
        step_div = 32'd2;
        run = 1'b1;
        cyc(12);
        dt = W'(8192);
        cyc(12);
        sigma = W'(5242880);
        rho = W'(10485760);
        cyc(12);
        run = 1'b0;
        cyc(2);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
